// File: rtl/pkt_tx_serializer_pkg.sv
// Shared network definitions: packet type codes, per-type payload lengths,
// header layout and captured-field slots used by the TX serializer.
package pkt_tx_serializer_pkg;

  typedef enum logic [2:0] {
    PKT_HB      = 3'b000,
    PKT_CHE     = 3'b001,
    PKT_INV     = 3'b010,
    PKT_MR      = 3'b011,
    PKT_CHT     = 3'b100,
    PKT_DATA    = 3'b101,
    PKT_SOS     = 3'b110,
    PKT_INVALID = 3'b111
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_state_e;

  localparam int unsigned TYPE_W     = 3;
  localparam int unsigned LEN_W      = 5;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned HDR_W      = 16;
  localparam int unsigned HDR_TYPE_LSB = 13;
  localparam int unsigned HDR_LEN_LSB  = 8;

  localparam int unsigned LEN_HB   = 3;
  localparam int unsigned LEN_INV  = 3;
  localparam int unsigned LEN_MR   = 4;
  localparam int unsigned LEN_CHT  = 3;
  localparam int unsigned LEN_DATA = 5;

  // Slots of the captured-field array
  localparam int unsigned NUM_FIELDS = 7;
  localparam int unsigned F_SRC      = 0;
  localparam int unsigned F_ENERGY   = 1;
  localparam int unsigned F_QVALUE   = 2;
  localparam int unsigned F_SRCHOPS  = 3;
  localparam int unsigned F_DEST     = 4;
  localparam int unsigned F_CHOSENCH = 5;
  localparam int unsigned F_HOPSCH   = 6;

  function automatic logic is_tx_type(input logic [TYPE_W-1:0] t);
    return !((t == PKT_CHE) || (t == PKT_INVALID));
  endfunction

  function automatic logic [LEN_W-1:0] pkt_len(input logic [TYPE_W-1:0] t);
    logic [LEN_W-1:0] len;
    case (pkt_type_e'(t))
      PKT_HB:             len = LEN_W'(LEN_HB);
      PKT_INV:            len = LEN_W'(LEN_INV);
      PKT_MR:             len = LEN_W'(LEN_MR);
      PKT_CHT:            len = LEN_W'(LEN_CHT);
      PKT_DATA, PKT_SOS:  len = LEN_W'(LEN_DATA);
      default:            len = '0;
    endcase
    return len;
  endfunction

  function automatic logic [HDR_W-1:0] pkt_header(input logic [TYPE_W-1:0] t);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_TYPE_LSB +: TYPE_W] = t;
    h[HDR_LEN_LSB +: LEN_W]   = pkt_len(t);
    return h;
  endfunction

endpackage

// File: rtl/pkt_tx_serializer_word_sel.sv
// Stateless selector: maps (packet type, word index, captured fields) to the
// serial word; index 0 is the header, indices beyond LEN give zero.
module pkt_word_sel
  import pkt_tx_serializer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic [TYPE_W-1:0]                     i_type,
  input  logic [IDX_W-1:0]                      i_idx,
  input  logic [NUM_FIELDS-1:0][WORD_WIDTH-1:0] i_fields,
  output logic [WORD_WIDTH-1:0]                 o_word_c
);

  always_comb begin
    o_word_c = '0;
    if (i_idx == '0) begin
      o_word_c = WORD_WIDTH'(pkt_header(i_type));
    end else begin
      case (pkt_type_e'(i_type))
        PKT_HB: begin
          case (i_idx)
            3'd1:    o_word_c = i_fields[F_SRC];
            3'd2:    o_word_c = i_fields[F_SRCHOPS];
            3'd3:    o_word_c = i_fields[F_ENERGY];
            default: o_word_c = '0;
          endcase
        end
        PKT_INV: begin
          case (i_idx)
            3'd1:    o_word_c = i_fields[F_SRC];
            3'd2:    o_word_c = i_fields[F_CHOSENCH];
            3'd3:    o_word_c = i_fields[F_HOPSCH];
            default: o_word_c = '0;
          endcase
        end
        PKT_MR: begin
          case (i_idx)
            3'd1:    o_word_c = i_fields[F_SRC];
            3'd2:    o_word_c = i_fields[F_DEST];
            3'd3:    o_word_c = i_fields[F_ENERGY];
            3'd4:    o_word_c = i_fields[F_QVALUE];
            default: o_word_c = '0;
          endcase
        end
        PKT_CHT: begin
          case (i_idx)
            3'd1:    o_word_c = i_fields[F_SRC];
            3'd2:    o_word_c = i_fields[F_DEST];
            3'd3:    o_word_c = i_fields[F_CHOSENCH];
            default: o_word_c = '0;
          endcase
        end
        PKT_DATA, PKT_SOS: begin
          case (i_idx)
            3'd1:    o_word_c = i_fields[F_SRC];
            3'd2:    o_word_c = i_fields[F_DEST];
            3'd3:    o_word_c = i_fields[F_ENERGY];
            3'd4:    o_word_c = i_fields[F_QVALUE];
            3'd5:    o_word_c = i_fields[F_SRCHOPS];
            default: o_word_c = '0;
          endcase
        end
        default: o_word_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/pkt_tx_serializer.sv
// Captures reward-stage fields on a rising reward_done and streams the packet
// as header + payload words over a valid/ready interface; counts dropped requests.
module pkt_tx_serializer
  import pkt_tx_serializer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  reward_done,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  input  logic [TYPE_W-1:0]     rPacketType,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  tx_done,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  tx_state_e                            r_state, w_state_nxt;
  logic [TYPE_W-1:0]                    r_type, w_type_nxt;
  logic [IDX_W-1:0]                     r_idx, w_idx_nxt;
  logic [NUM_FIELDS-1:0][WORD_WIDTH-1:0] r_fields, w_fields_nxt, w_cap_fields;
  logic                                 r_rd_d, r_armed;
  logic [WORD_WIDTH-1:0]                r_tx_data;
  logic                                 r_tx_valid, r_tx_last, r_busy, r_tx_done;
  logic [DROP_CNT_W-1:0]                r_drop_cnt;
  logic                                 w_trig, w_hs, w_drop, w_send_nxt;
  logic [WORD_WIDTH-1:0]                w_word_nxt;

  // r_armed blocks a level already high at reset release from counting as an edge
  assign w_trig = reward_done & ~r_rd_d & r_armed;
  assign w_hs   = r_tx_valid & tx_ready;

  always_comb begin
    w_cap_fields             = '0;
    w_cap_fields[F_SRC]      = rSourceID;
    w_cap_fields[F_ENERGY]   = rEnergyLeft;
    w_cap_fields[F_QVALUE]   = rQValue;
    w_cap_fields[F_SRCHOPS]  = rSourceHops;
    w_cap_fields[F_DEST]     = rDestinationID;
    w_cap_fields[F_CHOSENCH] = rChosenCH;
    w_cap_fields[F_HOPSCH]   = rHopsFromCH;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= ST_IDLE;
      r_type   <= '0;
      r_idx    <= '0;
      r_fields <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_type   <= w_type_nxt;
      r_idx    <= w_idx_nxt;
      r_fields <= w_fields_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_type_nxt   = r_type;
    w_idx_nxt    = r_idx;
    w_fields_nxt = r_fields;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          if (is_tx_type(rPacketType)) begin
            w_state_nxt  = ST_SEND;
            w_type_nxt   = rPacketType;
            w_idx_nxt    = '0;
            w_fields_nxt = w_cap_fields;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      ST_SEND: begin
        w_drop = w_trig;
        if (w_hs) begin
          if (r_tx_last) w_state_nxt = ST_DONE;
          else           w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      ST_DONE: begin
        w_drop      = w_trig;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Word is selected from next-cycle state so the TX outputs can be registered
  pkt_word_sel #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_word_sel (
    .i_type  (w_type_nxt),
    .i_idx   (w_idx_nxt),
    .i_fields(w_fields_nxt),
    .o_word_c(w_word_nxt)
  );

  assign w_send_nxt = (w_state_nxt == ST_SEND);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_d     <= 1'b0;
      r_armed    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_rd_d     <= reward_done;
      r_armed    <= r_armed | ~reward_done;
      r_tx_data  <= w_send_nxt ? w_word_nxt : '0;
      r_tx_valid <= w_send_nxt;
      r_tx_last  <= w_send_nxt && (LEN_W'(w_idx_nxt) == pkt_len(w_type_nxt));
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_tx_done  <= (w_state_nxt == ST_DONE);
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign tx_last  = r_tx_last;
  assign busy     = r_busy;
  assign tx_done  = r_tx_done;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pkt_tx_serializer.sv
// Scoreboard bench for pkt_tx_serializer: stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake.
module tb_pkt_tx_serializer;

  localparam int unsigned WW = 16;
  localparam int unsigned DW = 8;

  logic          clk, nrst, reward_done, tx_ready;
  logic [WW-1:0] rSourceID, rEnergyLeft, rQValue, rSourceHops;
  logic [WW-1:0] rDestinationID, rChosenCH, rHopsFromCH;
  logic [2:0]    rPacketType;
  logic [WW-1:0] tx_data;
  logic          tx_valid, tx_last, busy, tx_done;
  logic [DW-1:0] drop_cnt;

  pkt_tx_serializer #(.WORD_WIDTH(WW), .DROP_CNT_W(DW)) dut (
    .clk(clk), .nrst(nrst), .reward_done(reward_done),
    .rSourceID(rSourceID), .rEnergyLeft(rEnergyLeft), .rQValue(rQValue),
    .rSourceHops(rSourceHops), .rDestinationID(rDestinationID),
    .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH), .rPacketType(rPacketType),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .tx_done(tx_done), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } exp_t;

  exp_t q[$];
  logic exp_done_next = 1'b0;
  int   exp_drop = 0;
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  int   ready_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: header LEN is simply the size of the payload list built per type
  function automatic void model_push(input logic [2:0] t, input logic [WW-1:0] f [7]);
    logic [WW-1:0] pay[$];
    logic [WW-1:0] hdr;
    case (t)
      3'd0: begin pay.push_back(f[0]); pay.push_back(f[3]); pay.push_back(f[1]); end
      3'd2: begin pay.push_back(f[0]); pay.push_back(f[5]); pay.push_back(f[6]); end
      3'd3: begin pay.push_back(f[0]); pay.push_back(f[4]); pay.push_back(f[1]);
                  pay.push_back(f[2]); end
      3'd4: begin pay.push_back(f[0]); pay.push_back(f[4]); pay.push_back(f[5]); end
      3'd5, 3'd6: begin pay.push_back(f[0]); pay.push_back(f[4]); pay.push_back(f[1]);
                  pay.push_back(f[2]); pay.push_back(f[3]); end
      default: ;
    endcase
    hdr = {t, 5'(pay.size()), 8'h00};
    q.push_back('{data: hdr, last: 1'b0});
    for (int i = 0; i < pay.size(); i++)
      q.push_back('{data: pay[i], last: (i == pay.size() - 1)});
  endfunction

  task automatic rand_fields(output logic [WW-1:0] f [7]);
    for (int i = 0; i < 7; i++) f[i] = WW'($urandom);
  endtask

  // Raise reward_done for 'hold' cycles; model decides capture or drop
  task automatic send_trig(input logic [2:0] t, input logic [WW-1:0] f [7], input int hold);
    bit busy_now;
    rPacketType = t;
    rSourceID = f[0]; rEnergyLeft = f[1]; rQValue = f[2]; rSourceHops = f[3];
    rDestinationID = f[4]; rChosenCH = f[5]; rHopsFromCH = f[6];
    busy_now = (q.size() != 0) || exp_done_next;
    reward_done = 1'b1;
    @(posedge clk); #1;
    if (busy_now || t == 3'd1 || t == 3'd7) begin
      if (exp_drop < 255) exp_drop++;
    end else begin
      model_push(t, f);
    end
    for (int i = 1; i < hold; i++) begin @(posedge clk); #1; end
    reward_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || exp_done_next) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d words still expected", q.size());
    end
    @(posedge clk); #1;
  endtask

  // Ready pattern generator
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       begin tx_ready = ((ready_cnt % 3) == 0); ready_cnt++; end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t          e;
    logic          prev_stall, new_done, prev_last;
    logic [WW-1:0] prev_data;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev_stall = 1'b0;
      end else begin
        chk("tx_done", tx_done, exp_done_next);
        chk("busy", busy, (q.size() != 0) || exp_done_next);
        chk("tx_valid", tx_valid, q.size() != 0);
        if (!tx_valid) begin
          chk("idle_data", tx_data, 0);
          chk("idle_last", tx_last, 0);
        end
        if (prev_stall) begin
          chk("stall_data", tx_data, prev_data);
          chk("stall_last", tx_last, prev_last);
        end
        new_done = 1'b0;
        if (tx_valid && tx_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("word_data", tx_data, e.data);
          chk("word_last", tx_last, e.last);
          new_done = e.last;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
        exp_done_next = new_done;
      end
    end
  end

  initial begin
    logic [WW-1:0] f [7];
    logic [2:0]    t;
    nrst = 1'b0; reward_done = 1'b0; rPacketType = '0;
    rSourceID = '0; rEnergyLeft = '0; rQValue = '0; rSourceHops = '0;
    rDestinationID = '0; rChosenCH = '0; rHopsFromCH = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data", tx_data, 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // HB with fixed fields, always ready
    ready_mode = 0;
    for (int i = 0; i < 7; i++) f[i] = '0;
    f[0] = 16'h0005; f[3] = 16'h0002; f[1] = 16'h0190;
    send_trig(3'd0, f, 1);
    wait_idle();

    // Data with stalls
    ready_mode = 1; ready_cnt = 0;
    rand_fields(f);
    send_trig(3'd5, f, 1);
    wait_idle();

    // Untransmittable types
    rand_fields(f);
    send_trig(3'd7, f, 1);
    send_trig(3'd1, f, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("drop_after_bad_types", drop_cnt, 2);

    // Level held high for 3 cycles
    ready_mode = 0;
    rand_fields(f);
    send_trig(3'd3, f, 3);
    wait_idle();

    // Trigger during an INV packet
    ready_mode = 1; ready_cnt = 0;
    rand_fields(f);
    send_trig(3'd2, f, 1);
    rand_fields(f);
    send_trig(3'd4, f, 1);
    wait_idle();
    chk("drop_after_busy_trig", drop_cnt, 3);

    // Reset while word 2 of a Data packet is presented
    ready_mode = 0;
    rand_fields(f);
    send_trig(3'd5, f, 1);
    @(posedge clk); #1;
    nrst = 1'b0;
    q.delete();
    exp_done_next = 1'b0;
    exp_drop = 0;
    #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_last", tx_last, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", tx_done, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    rand_fields(f);
    send_trig(3'd4, f, 1);
    wait_idle();

    // Randomized traffic, including triggers that land while busy
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      t = 3'($urandom_range(0, 7));
      rand_fields(f);
      send_trig(t, f, int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
    end
    wait_idle();
    chk("drop_random", drop_cnt, exp_drop);

    // Saturation of the drop counter
    rand_fields(f);
    for (int n = 0; n < 260; n++) send_trig(3'd7, f, 1);
    @(posedge clk); #1;
    chk("drop_saturate", drop_cnt, exp_drop);
    chk("drop_all_ones", drop_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
